// File: rtl/pll_phase_cal_pkg.sv
// Shared types for the PSRAM rPLL phase calibration block: FSM states,
// PSDA constants and the pass-window result.
package psram_cal_pkg;

  localparam logic [3:0] PSDA_DEFAULT = 4'b0100;
  localparam int         NUM_PHASES   = 16;

  typedef enum logic [2:0] {
    IDLE, SET_PHASE, SETTLE, REQ, PICK, FINISH
  } cal_state_e;

  typedef struct packed {
    logic [3:0] start;
    logic [4:0] len;
  } win_t;

  // Middle of the window, rounding toward the start; wraps mod 16.
  function automatic logic [3:0] win_centre(win_t w);
    logic [4:0] half;
    half = (w.len - 5'd1) >> 1;
    return w.start + half[3:0];
  endfunction

endpackage

// File: rtl/pll_phase_cal_if.sv
// Trial handshake between the calibration controller and the PSRAM
// controller's self-test port.
interface pll_phase_cal_if;
  logic trial_req;
  logic trial_ack;
  logic trial_pass;

  modport master (output trial_req, input trial_ack, input trial_pass);
  modport slave  (input trial_req, output trial_ack, output trial_pass);
endinterface

// File: rtl/pll_phase_cal_phase_window_finder.sv
// Sequential scan for the widest circular run of ones in a 16-bit mask.
// Walks the mask twice (32 cycles) so runs crossing bit 15 -> 0 are seen whole.
module phase_window_finder
  import psram_cal_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mask,
  input  logic        go,
  output win_t        win,
  output logic        valid
);

  logic [15:0] mask_q, mask_d;
  logic        act_q, act_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  run_q, run_d;
  logic [3:0]  cur_q, cur_d;
  win_t        best_q, best_d;
  logic        valid_q, valid_d;

  always_comb begin
    mask_d  = mask_q;
    act_d   = act_q;
    idx_d   = idx_q;
    run_d   = run_q;
    cur_d   = cur_q;
    best_d  = best_q;
    valid_d = 1'b0;
    if (go && !act_q) begin
      mask_d = mask;
      act_d  = 1'b1;
      idx_d  = '0;
      run_d  = '0;
      cur_d  = '0;
      best_d = '0;
    end else if (act_q) begin
      if (mask_q[idx_q[3:0]]) begin
        run_d = (run_q == 5'd16) ? 5'd16 : run_q + 5'd1;
        cur_d = (run_q == 5'd0) ? idx_q[3:0] : cur_q;
        // Strict compare: the earliest-starting run of a given length is kept.
        if (run_d > best_q.len) begin
          best_d.len   = run_d;
          best_d.start = cur_d;
        end
      end else begin
        run_d = '0;
      end
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) begin
        act_d   = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= '0;
      act_q   <= 1'b0;
      idx_q   <= '0;
      run_q   <= '0;
      cur_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      cur_q   <= cur_d;
      best_q  <= best_d;
      valid_q <= valid_d;
    end
  end

  assign win   = best_q;
  assign valid = valid_q;

endmodule

// File: rtl/pll_phase_cal.sv
// Sweeps the rPLL PSDA phase over 16 steps, runs PSRAM test reads at each,
// then parks PSDA at the centre of the widest passing window.
module pll_phase_cal
  import psram_cal_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 64,
  parameter int TRIALS         = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [3:0]             pll_psda,
  pll_phase_cal_if.master        trial,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [15:0]            pass_mask,
  output logic [4:0]             window_len
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  cal_state_e  state_q, state_d;
  logic [3:0]  p_q, p_d, psda_q, psda_d, trial_q, trial_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        req_q, req_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d, go_q, go_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  wlen_q, wlen_d;
  logic        trial_end, trial_ok;
  win_t        win;
  logic        win_valid;

  phase_window_finder u_finder (
    .clk   (clk),
    .rst   (rst),
    .mask  (mask_q),
    .go    (go_q),
    .win   (win),
    .valid (win_valid)
  );

  assign trial_end = trial.trial_ack || (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign trial_ok  = trial.trial_ack && trial.trial_pass;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    psda_d  = psda_q;
    trial_d = trial_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    mask_d  = mask_q;
    wlen_d  = wlen_q;
    go_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        done_d  = 1'b0;
        fail_d  = 1'b0;
        mask_d  = '0;
        p_d     = '0;
        state_d = SET_PHASE;
      end
      SET_PHASE: begin
        psda_d  = p_q;
        busy_d  = 1'b1;
        cnt_d   = 10'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          trial_d = '0;
          tmo_d   = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      REQ: begin
        if (!req_q) begin
          // one idle cycle between back-to-back trials
          req_d = 1'b1;
          tmo_d = '0;
        end else if (trial_end) begin
          req_d = 1'b0;
          // a phase only reaches its last trial if all earlier ones passed
          if (!trial_ok || trial_q == 4'(TRIALS - 1)) begin
            mask_d[p_q] = trial_ok;
            if (p_q == 4'd15) begin
              go_d    = 1'b1;
              state_d = PICK;
            end else begin
              p_d     = p_q + 4'd1;
              state_d = SET_PHASE;
            end
          end else begin
            trial_d = trial_q + 4'd1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PICK: if (win_valid) state_d = FINISH;
      FINISH: begin
        if (win.len == 5'd0) begin
          psda_d = PSDA_DEFAULT;
          fail_d = 1'b1;
        end else if (win.len == 5'd16) begin
          psda_d = PSDA_DEFAULT;
        end else begin
          psda_d = win_centre(win);
        end
        wlen_d  = win.len;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      psda_q  <= PSDA_DEFAULT;
      trial_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      mask_q  <= '0;
      wlen_q  <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      psda_q  <= psda_d;
      trial_q <= trial_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      mask_q  <= mask_d;
      wlen_q  <= wlen_d;
      go_q    <= go_d;
    end
  end

  assign trial.trial_req = req_q;
  assign pll_psda        = psda_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign pass_mask       = mask_q;
  assign window_len      = wlen_q;

endmodule

// File: tb/tb_pll_phase_cal.sv
// Scoreboarded bench for pll_phase_cal: a per-phase behaviour table drives a
// randomized-latency responder; expected sweep results come from a window model.
module tb_pll_phase_cal;
  import psram_cal_pkg::*;

  localparam int SETTLE = 8;
  localparam int TRIALS = 3;
  localparam int TMO    = 20;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  pll_psda;
  logic        busy, done, fail;
  logic [15:0] pass_mask;
  logic [4:0]  window_len;

  pll_phase_cal_if tif ();

  pll_phase_cal #(.SETTLE_CYCLES(SETTLE), .TRIALS(TRIALS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pll_psda   (pll_psda),
    .trial      (tif.master),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .pass_mask  (pass_mask),
    .window_len (window_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          len;
    logic [3:0]  psda;
    logic        fail;
    int          reqs;
  } exp_t;

  exp_t sbq[$];
  int   mode[16];   // 0 fails, 1 passes, 2 never acks, 3 last trial fails
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: evaluate every circular start, keep the first strictly longer run.
  function automatic exp_t model();
    exp_t e;
    int bl, bs, l;
    bl = 0; bs = 0;
    e.mask = '0; e.reqs = 0;
    for (int p = 0; p < 16; p++) begin
      e.mask[p] = (mode[p] == 1);
      e.reqs   += (mode[p] == 1 || mode[p] == 3) ? TRIALS : 1;
    end
    for (int s = 0; s < 16; s++) begin
      l = 0;
      while (l < 16 && e.mask[(s + l) % 16]) l++;
      if (l > bl) begin bl = l; bs = s; end
    end
    e.len  = bl;
    e.fail = (bl == 0);
    e.psda = (bl == 0 || bl == 16) ? 4'd4 : 4'((bs + (bl - 1) / 2) % 16);
    return e;
  endfunction

  task automatic set_pass(input logic [15:0] bits);
    for (int p = 0; p < 16; p++) mode[p] = bits[p] ? 1 : 0;
  endtask

  // Responder: random 0..3 cycle ack latency, outcome from the phase table.
  initial begin
    int wait_left, tip;
    logic pending;
    logic [3:0] last_psda;
    tif.trial_ack = 1'b0; tif.trial_pass = 1'b0;
    pending = 1'b0; wait_left = 0; tip = 0; last_psda = 4'hf;
    forever begin
      @(posedge clk); #1;
      tif.trial_ack = 1'b0; tif.trial_pass = 1'b0;
      if (rst || !tif.trial_req) begin
        pending = 1'b0;
      end else begin
        if (!pending) begin
          if (pll_psda !== last_psda) tip = 0;
          last_psda = pll_psda;
          tip++;
          req_cnt++;
          pending   = 1'b1;
          wait_left = $urandom_range(0, 3);
        end
        if (mode[pll_psda] != 2) begin
          if (wait_left == 0) begin
            tif.trial_ack  = 1'b1;
            tif.trial_pass = (mode[pll_psda] == 1) || (mode[pll_psda] == 3 && tip < TRIALS);
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Monitor: pop expectation on each rising done.
  initial begin
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && done && !done_prev) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("pass_mask", pass_mask, e.mask);
          chk("window_len", window_len, e.len);
          chk("pll_psda", pll_psda, e.psda);
          chk("fail", fail, e.fail);
          chk("busy_at_done", busy, 0);
          chk("trial_count", req_cnt, e.reqs);
        end
      end
      done_prev = done;
    end
  end

  // Handshake timing: settle length and timeout length.
  initial begin
    int cyc, chg_cyc, hi;
    logic req_prev, acked, chg_vld;
    logic [3:0] psda_prev;
    cyc = 0; chg_cyc = 0; hi = 0;
    req_prev = 1'b0; acked = 1'b0; chg_vld = 1'b0; psda_prev = 4'd4;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        req_prev = 1'b0; chg_vld = 1'b0; acked = 1'b0;
      end else begin
        if (pll_psda !== psda_prev && busy) begin chg_cyc = cyc; chg_vld = 1'b1; end
        if (tif.trial_req) begin
          if (!req_prev) begin
            hi = 0; acked = 1'b0;
            if (chg_vld) chk("settle_len", cyc - chg_cyc, SETTLE);
            chg_vld = 1'b0;
          end
          hi++;
          if (tif.trial_ack) acked = 1'b1;
        end else if (req_prev && !acked) begin
          chk("timeout_len", hi, TMO);
        end
        req_prev = tif.trial_req;
      end
      psda_prev = pll_psda;
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 5000) begin @(negedge clk); i++; end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic sweep(input bit extra_start);
    @(posedge clk); #1;
    req_cnt = 0;
    sbq.push_back(model());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_n1", busy, 0);
    @(negedge clk);
    chk("busy_n2", busy, 1);
    chk("psda_n2", pll_psda, 0);
    if (extra_start) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int i;
    rst = 1'b1; start = 1'b0;
    set_pass(16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_psda", pll_psda, 4);
    chk("rst_req", tif.trial_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_mask", pass_mask, 0);
    chk("rst_wlen", window_len, 0);
    @(posedge clk); #1 rst = 1'b0;

    set_pass(16'h03E0); sweep(0);
    set_pass(16'hC003); sweep(0);
    set_pass(16'h1C1C); sweep(0);
    set_pass(16'h0000); sweep(0);
    set_pass(16'hFFFF); sweep(0);

    for (int p = 0; p < 16; p++) mode[p] = $urandom_range(0, 3) == 0 ? 0 : ($urandom_range(0, 3) == 0 ? 3 : 1);
    mode[3] = 2;
    sweep(1);

    // Abort during settle of phase 6.
    set_pass(16'hFFFF);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0;
    while (pll_psda != 4'd6 && i < 2000) begin @(negedge clk); i++; end
    chk("reach_phase6", pll_psda, 6);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("arst_psda", pll_psda, 4);
    chk("arst_req", tif.trial_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_mask", pass_mask, 0);
    chk("arst_wlen", window_len, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    for (int n = 0; n < 4; n++) begin
      for (int p = 0; p < 16; p++) mode[p] = $urandom_range(0, 3) == 0 ? 0 : ($urandom_range(0, 4) == 0 ? 3 : 1);
      sweep(0);
    end

    repeat (5) @(negedge clk);
    if (sbq.size() != 0) chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_phase_cal.md
# pll_phase_cal

Calibration controller for the dynamic phase-shift port of the PSRAM rPLL. It sweeps the 4-bit PSDA phase setting across all 16 steps and requests test reads from the PSRAM controller at each step. It records which phases pass, then programs the centre of the widest circular pass window. It sits between the clock-generation wrapper (configured with DYN_DA_EN = true) and the PSRAM controller's self-test port, all in the system clock domain.

## Interface
Parameters:
- SETTLE_CYCLES, 64: clk cycles waited after every PSDA change before the first trial; range 1..1023.
- TRIALS, 4: test reads per phase; a phase passes only if all trials pass; range 1..15.
- TIMEOUT_CYCLES, 256: maximum cycles trial_req may stay high without trial_ack; on expiry the trial counts as a fail.

Ports:
- clk, input, 1: system clock; the block's only clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that begins calibration; ignored while busy.
- pll_psda, output, 4: drives the rPLL PSDA input.
- trial_req, output, 1: request for one PSRAM test read.
- trial_ack, input, 1: single-cycle completion pulse for a trial; ignored unless trial_req is high.
- trial_pass, input, 1: trial result, sampled only in the trial_ack cycle.
- busy, output, 1: high from the cycle after start is accepted until the cycle done rises.
- done, output, 1: sticky; cleared when the next start is accepted.
- fail, output, 1: sticky; set together with done when no phase passed.
- pass_mask, output, 16: bit p = phase p passed; valid while done is high.
- window_len, output, 5: length of the selected window, 0..16.

## Operation
- Reset values:
  - pll_psda = 4'b0100 (PSDA_DEFAULT)
  - trial_req = 0, busy = 0, done = 0, fail = 0
  - pass_mask = 0, window_len = 0
  - FSM in IDLE
- FSM states: IDLE, SET_PHASE, SETTLE, REQ, PICK, FINISH.
- IDLE: on start, clear done, fail and pass_mask, set phase p = 0, go to SET_PHASE.
- SET_PHASE: set pll_psda = p, load the settle counter, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ with trial count = 0.
- REQ:
  - Hold trial_req high until trial_ack or timeout.
  - A trial fails if trial_pass = 0 at the ack or on timeout; any failed trial marks phase p failed.
  - After TRIALS trials, write pass_mask[p].
  - If p = 15, go to PICK; otherwise increment p and go to SET_PHASE.
- Early exit: once a trial of phase p fails, the remaining trials for p are skipped.
- PICK: find the longest run of consecutive set bits in pass_mask, treated circularly (15 wraps to 0).
  - Tie-break: lowest start index wins.
  - Centre = (start + (len-1)/2) mod 16, integer division, 4-bit wrap.
- FINISH:
  - len 1..15: pll_psda = centre, window_len = len.
  - len 0: pll_psda = 4'b0100, fail = 1, window_len = 0.
  - len 16: pll_psda = 4'b0100, window_len = 16.
  - In all cases set done = 1, busy = 0, and return to IDLE.
- pll_psda holds its last value in IDLE.
- Reset during any state: all outputs return to their reset values immediately; trial_req drops without waiting for an ack; an outstanding trial_ack is then ignored.

## Timing
- start sampled high in cycle N: busy = 1 and pll_psda = 0 in cycle N+2.
- SETTLE lasts exactly SETTLE_CYCLES cycles.
- trial_req handshake:
  - Rises on the first REQ cycle.
  - Falls the cycle after trial_ack is sampled.
  - Stays low for exactly 1 cycle between back-to-back trials.
- Timeout: trial_req falls TIMEOUT_CYCLES cycles after it rose.
- trial_ack in the same cycle trial_req rises is valid; the minimum trial takes 1 cycle of req.
- PICK is sequential: it scans 32 positions (the mask concatenated with itself), one per cycle, so it takes 32 cycles. Runs are capped at 16.
- done and the final pll_psda update in the same cycle.

## Structure
- psram_cal_pkg holds:
  - the state enum;
  - PSDA_DEFAULT = 4'b0100;
  - NUM_PHASES = 16;
  - the window-result struct {start[3:0], len[4:0]}.
- Sub-module phase_window_finder holds the PICK scan:
  - inputs: mask[15:0] and a go pulse;
  - outputs: start, len, and a valid pulse after 32 cycles.

## Test plan
- Responder passes phases 5..9 only -> pass_mask = 16'h03E0, window_len = 5, pll_psda = 7, fail = 0.
- Responder passes phases 14, 15, 0 and 1 -> pass_mask = 16'hC003, window_len = 4, pll_psda = 15 (wrap).
- Two windows, 2..4 and 10..12 -> window_len = 3, pll_psda = 3 (lowest start wins the tie).
- Responder never passes -> fail = 1, done = 1, window_len = 0, pll_psda = 4.
- Responder always passes -> window_len = 16, pll_psda = 4.
- Responder never acks phase 3 -> each timeout fires at TIMEOUT_CYCLES, bit 3 = 0, and the sweep continues.
- start pulsed while busy -> ignored.
- rst asserted during SETTLE of phase 6 -> all outputs return to reset values the same cycle; a following start completes a normal sweep.
